d05200_otp_ctrl: RTL

D05200_OTP_CTRL -- requirements
Module: d05200_otp_ctrl

---
 rtl/d05200_otp_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/d05200_otp_ctrl.sv
// OTP macro controller: boot-time trim load followed by host read and program/verify access.
// Every macro strobe and host-facing output is a flop, loaded from the next-state value.
module d05200_otp_ctrl #(
  parameter int T_RD       = 4,
  parameter int T_PG       = 200,
  parameter int BOOT_WORDS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_vld,
  output logic       req_rdy,
  input  logic       req_wr,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic       prog_en,
  output logic       rsp_vld,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       boot_done,
  output logic [7:0] lcfr,
  output logic [7:0] hcfr,
  output logic       otp_cs,
  output logic       otp_read,
  output logic       otp_prog,
  output logic [6:0] otp_addr,
  output logic [7:0] otp_dati,
  input  logic [7:0] otp_dato
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] BOOT     = 4'd1;
  localparam logic [3:0] RD_SU    = 4'd2;
  localparam logic [3:0] RD_PULSE = 4'd3;
  localparam logic [3:0] RD_HOLD  = 4'd4;
  localparam logic [3:0] PG_SU    = 4'd5;
  localparam logic [3:0] PG_PULSE = 4'd6;
  localparam logic [3:0] PG_HOLD  = 4'd7;
  localparam logic [3:0] VERIFY   = 4'd8;
  localparam logic [3:0] RESP     = 4'd9;

  // A 16-bit counter covers the longest legal program pulse without wrapping.
  localparam logic [15:0] RD_LAST   = 16'(T_RD - 1);
  localparam logic [15:0] PG_LAST   = 16'(T_PG - 1);
  localparam logic [2:0]  BOOT_LAST = 3'(BOOT_WORDS - 1);

  logic [3:0]  state;
  logic [3:0]  next_state;
  logic [15:0] cnt;
  logic [2:0]  boot_idx;
  logic        req_wr_q;
  logic [7:0]  rd_byte;
  logic        accept;
  logic        rd_last;
  logic        pg_last;
  logic        boot_last;
  logic        boot_done_next;
  logic        in_pulse;

  assign accept         = (state == IDLE) && req_rdy && req_vld;
  assign rd_last        = (state == RD_PULSE) && (cnt == RD_LAST);
  assign pg_last        = (state == PG_PULSE) && (cnt == PG_LAST);
  assign boot_last      = (boot_idx == BOOT_LAST);
  assign boot_done_next = boot_done || ((state == RD_HOLD) && boot_last);
  assign in_pulse       = (state == RD_PULSE) || (state == PG_PULSE);

  // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!boot_done)  next_state = BOOT;
        else if (accept) next_state = !req_wr ? RD_SU : (prog_en ? PG_SU : RESP);
      end
      // BOOT and VERIFY double as the one-cycle read setup phase of their read.
      BOOT, RD_SU, VERIFY: next_state = RD_PULSE;
      RD_PULSE: if (rd_last) next_state = RD_HOLD;
      RD_HOLD: begin
        if (!boot_done) next_state = boot_last ? IDLE : BOOT;
        else            next_state = RESP;
      end
      PG_SU:    next_state = PG_PULSE;
      PG_PULSE: if (pg_last) next_state = PG_HOLD;
      PG_HOLD:  next_state = VERIFY;
      RESP:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      boot_idx  <= '0;
      req_wr_q  <= 1'b0;
      rd_byte   <= '0;
      req_rdy   <= 1'b0;
      rsp_vld   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      boot_done <= 1'b0;
      lcfr      <= '0;
      hcfr      <= '0;
      otp_cs    <= 1'b0;
      otp_read  <= 1'b0;
      otp_prog  <= 1'b0;
      otp_addr  <= '0;
      otp_dati  <= '0;
    end else begin
      state     <= next_state;
      otp_cs    <= (next_state != IDLE) && (next_state != RESP);
      otp_read  <= (next_state == RD_PULSE);
      otp_prog  <= (next_state == PG_PULSE);
      boot_done <= boot_done_next;
      req_rdy   <= (next_state == IDLE) && boot_done_next;
      rsp_vld   <= (next_state == RESP);
      cnt       <= (in_pulse && (next_state == state)) ? cnt + 16'd1 : 16'd0;

      if ((state == IDLE) && !boot_done) begin
        boot_idx <= '0;
        otp_addr <= '0;
      end
      if ((state == RD_HOLD) && !boot_done && !boot_last) begin
        boot_idx <= boot_idx + 3'd1;
        otp_addr <= 7'(boot_idx + 3'd1);
      end

      if (accept) begin
        otp_addr <= req_addr;
        req_wr_q <= req_wr;
        if (req_wr) otp_dati <= req_wdata;
      end

      if (rd_last) begin
        rd_byte <= otp_dato;
        if (!boot_done && (boot_idx == 3'd0)) lcfr <= otp_dato;
        if (!boot_done && (boot_idx == 3'd1)) hcfr <= otp_dato;
      end

      if (next_state == RESP) begin
        if (state == IDLE) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else begin
          rsp_rdata <= rd_byte;
          rsp_err   <= req_wr_q && (rd_byte != otp_dati);
        end
      end
    end
  end

endmodule
